// File: rtl/cache_miss_handler_pkg.sv
// Shared cache definitions: block geometry and miss-handler state encodings.
// The memory controller imports the same package, so encodings stay in sync.
package cache_miss_handler_pkg;

  localparam int CACHE_BLOCK_WORDS = 8;
  localparam int ADDR_W            = 16;
  localparam int CNT_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_FILL = 2'b10,
    ST_DONE = 2'b11
  } miss_state_e;

endpackage

// File: rtl/cache_miss_handler_cells.sv
// Library cells used by the miss handler: a resettable register and a
// 4-bit incrementer.

module dff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Plain register with asynchronous active-high clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VAL;
    else     q <= d;
  end

endmodule

module incrementer_4_bit (
  input  logic [3:0] a,
  output logic [3:0] y
);

  assign y = a + 4'd1;

endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: captures a missing access, requests a block fill from
// the memory controller, steers returned words into the data array and
// writes the tag once the controller reports the block complete.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no outstanding miss; a missing access is captured here
// REQ   | fill requested, waiting for the controller to start updating
// FILL  | words streaming in; tag write ends the fill
// DONE  | single-cycle completion pulse before returning to IDLE
module cache_miss_handler
  import cache_miss_handler_pkg::*;
#(
  parameter  int BLOCK_WORDS = CACHE_BLOCK_WORDS,
  localparam int OFS_W       = $clog2(BLOCK_WORDS),
  localparam int BLK_W       = 15 - OFS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             access_valid,
  input  logic [15:0]      access_address,
  input  logic             tag_hit,
  output logic             cache_miss,
  output logic [15:0]      cache_miss_address,
  input  logic             cache_updating,
  input  logic             cache_write_data_array,
  input  logic             cache_write_tag_array,
  input  logic [15:0]      ram_data_address,
  input  logic [15:0]      ram_data_out,
  output logic             data_we,
  output logic [OFS_W-1:0] data_word_offset,
  output logic [15:0]      data_wdata,
  output logic             tag_we,
  output logic [BLK_W-1:0] fill_block,
  output logic             stall,
  output logic             fill_done
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(BLOCK_WORDS);

  miss_state_e      state_q, state_d;
  logic [1:0]       state_raw;
  logic [15:0]      addr_q, addr_d;
  logic [CNT_W-1:0] word_count, count_inc, count_d;
  logic             miss_detect;
  logic             block_match;
  logic             unused_byte_bit;

  dff #(.WIDTH(2)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_raw)
  );

  dff #(.WIDTH(16)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .d   (addr_d),
    .q   (addr_q)
  );

  dff #(.WIDTH(CNT_W)) u_count_reg (
    .clk (clk),
    .rst (rst),
    .d   (count_d),
    .q   (word_count)
  );

  incrementer_4_bit u_count_inc (
    .a (word_count),
    .y (count_inc)
  );

  assign state_q            = miss_state_e'(state_raw);
  // Gated by rst so a miss presented during reset cannot raise stall.
  assign miss_detect        = access_valid & ~tag_hit & ~rst;
  assign block_match        = ram_data_address[15:OFS_W+1] == addr_q[15:OFS_W+1];
  assign cache_miss_address = addr_q;
  assign fill_block         = addr_q[15:OFS_W+1];
  assign unused_byte_bit    = ram_data_address[0];

  // Next-state, capture, word counter and all handshake outputs.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    count_d          = word_count;
    cache_miss       = 1'b0;
    stall            = 1'b0;
    data_we          = 1'b0;
    data_word_offset = '0;
    data_wdata       = '0;
    tag_we           = 1'b0;
    fill_done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (miss_detect) begin
          addr_d  = access_address;
          stall   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cache_miss = 1'b1;
        stall      = 1'b1;
        count_d    = '0;
        if (cache_updating) state_d = ST_FILL;
      end
      ST_FILL: begin
        cache_miss       = 1'b1;
        stall            = 1'b1;
        data_word_offset = ram_data_address[OFS_W:1];
        data_wdata       = ram_data_out;
        data_we          = cache_write_data_array & block_match;
        tag_we           = cache_write_tag_array;
        if (data_we && word_count != CNT_SAT) count_d = count_inc;
        // Completion does not depend on the word count.
        if (cache_write_tag_array) begin
          state_d = ST_DONE;
        end else if (!cache_updating) begin
          // Controller was preempted: ask again and refill from word 0.
          state_d = ST_REQ;
          count_d = '0;
        end
      end
      ST_DONE: begin
        stall     = 1'b1;
        fill_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler: directed scenarios plus randomized fills.
// A fill is modelled as a transaction: every word whose block matches the
// miss address is expected as a data write, then one tag write, then one
// completion pulse. A monitor pops these expectations as the DUT emits them.
module tb_cache_miss_handler;

  logic        clk;
  logic        rst;
  logic        access_valid;
  logic [15:0] access_address;
  logic        tag_hit;
  logic        cache_miss;
  logic [15:0] cache_miss_address;
  logic        cache_updating;
  logic        cache_write_data_array;
  logic        cache_write_tag_array;
  logic [15:0] ram_data_address;
  logic [15:0] ram_data_out;
  logic        data_we;
  logic [2:0]  data_word_offset;
  logic [15:0] data_wdata;
  logic        tag_we;
  logic [11:0] fill_block;
  logic        stall;
  logic        fill_done;

  cache_miss_handler #(.BLOCK_WORDS(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .access_valid           (access_valid),
    .access_address         (access_address),
    .tag_hit                (tag_hit),
    .cache_miss             (cache_miss),
    .cache_miss_address     (cache_miss_address),
    .cache_updating         (cache_updating),
    .cache_write_data_array (cache_write_data_array),
    .cache_write_tag_array  (cache_write_tag_array),
    .ram_data_address       (ram_data_address),
    .ram_data_out           (ram_data_out),
    .data_we                (data_we),
    .data_word_offset       (data_word_offset),
    .data_wdata             (data_wdata),
    .tag_we                 (tag_we),
    .fill_block             (fill_block),
    .stall                  (stall),
    .fill_done              (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 word write, 1 tag write, 2 completion pulse
    logic [2:0]  ofs;
    logic [15:0] data;
    logic [11:0] blk;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int kind, input logic [2:0] ofs,
                           input logic [15:0] data, input logic [11:0] blk);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected event: got kind %0d block 0x%0h, required no event (t=%0t)",
               kind, blk, $time);
    end else begin
      e = exp_q.pop_front();
      check("event kind", kind, e.kind);
      if (kind == 0 && e.kind == 0) begin
        check("word offset", ofs, e.ofs);
        check("word data", data, e.data);
      end
      check("event block", blk, e.blk);
    end
  endtask

  // Monitor: every write or completion the DUT presents must be expected.
  always @(negedge clk) begin
    if (data_we)   pop_check(0, data_word_offset, data_wdata, fill_block);
    if (tag_we)    pop_check(1, 3'd0, 16'd0, fill_block);
    if (fill_done) pop_check(2, 3'd0, 16'd0, fill_block);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    access_valid           = 1'b0;
    access_address         = 16'h0;
    tag_hit                = 1'b0;
    cache_updating         = 1'b0;
    cache_write_data_array = 1'b0;
    cache_write_tag_array  = 1'b0;
    ram_data_address       = 16'h0;
    ram_data_out           = 16'h0;
  endtask

  task automatic run_fill(input logic [15:0] addr, input int n_words, input bit preempt,
                          input bit rnd, input bit foreign_5670);
    logic [11:0] blk;
    int          waits;
    int          accepted;
    int          attempts;
    int          n;
    bit          last_attempt;
    bit          is_last;
    blk = addr[15:4];
    accepted = 0;

    step(); clear_inputs();
    access_valid = 1'b1; tag_hit = 1'b0; access_address = addr;
    #3;
    check("detect stall", stall, 1);
    check("detect cache_miss", cache_miss, 0);

    waits = rnd ? $urandom_range(0, 2) : 0;
    for (int w = 0; w <= waits; w++) begin
      step(); clear_inputs();
      access_valid   = rnd;
      access_address = 16'($urandom);
      cache_updating = (w == waits);
      if (rnd) begin
        cache_write_data_array = 1'($urandom);
        cache_write_tag_array  = 1'($urandom);
        ram_data_address       = {blk, 4'($urandom)};
        ram_data_out           = 16'($urandom);
      end
      #3;
      check("req cache_miss", cache_miss, 1);
      check("req miss address", cache_miss_address, addr);
      check("req stall", stall, 1);
      check("req data_we", data_we, 0);
      check("req tag_we", tag_we, 0);
    end

    attempts = preempt ? 2 : 1;
    for (int a = 0; a < attempts; a++) begin
      last_attempt = (a == attempts - 1);
      n = last_attempt ? n_words : 3;
      accepted = 0;
      for (int i = 0; i < n; i++) begin
        is_last = last_attempt && (i == n - 1);
        if (rnd && ($urandom % 3 == 0)) begin
          step(); clear_inputs();
          cache_updating   = 1'b1;
          ram_data_address = 16'($urandom);
          #3;
          check("gap data_we", data_we, 0);
        end
        if ((rnd && ($urandom % 4 == 0)) || (foreign_5670 && i == 2)) begin
          step(); clear_inputs();
          cache_updating         = 1'b1;
          cache_write_data_array = 1'b1;
          ram_data_address = foreign_5670 ? 16'h5670
                           : {blk ^ 12'($urandom_range(1, 4095)), 4'($urandom)};
          ram_data_out     = 16'($urandom);
          #3;
          check("foreign data_we", data_we, 0);
        end
        step(); clear_inputs();
        cache_updating         = 1'b1;
        cache_write_data_array = 1'b1;
        ram_data_address       = {blk, 3'(i % 8), 1'b0};
        ram_data_out           = rnd ? 16'($urandom) : 16'(16'hA0 + i);
        exp_q.push_back('{0, 3'(i % 8), ram_data_out, blk});
        accepted++;
        if (is_last) begin
          cache_write_tag_array = 1'b1;
          exp_q.push_back('{1, 3'd0, 16'd0, blk});
          exp_q.push_back('{2, 3'd0, 16'd0, blk});
        end
        #3;
        check("fill miss address", cache_miss_address, addr);
        check("fill tag_we", tag_we, 32'(is_last));
      end
      if (!last_attempt) begin
        step(); clear_inputs();
        #3;
        check("drop cycle tag_we", tag_we, 0);
        step(); clear_inputs();
        cache_updating         = 1'b1;
        cache_write_data_array = 1'b1;
        ram_data_address       = {blk, 4'h0};
        #3;
        check("preempt cache_miss", cache_miss, 1);
        check("preempt stall", stall, 1);
        check("preempt counter", dut.word_count, 0);
        check("preempt data_we", data_we, 0);
        check("preempt fill_done", fill_done, 0);
      end
    end

    step(); clear_inputs();
    #3;
    check("done fill_done", fill_done, 1);
    check("done stall", stall, 1);
    check("done cache_miss", cache_miss, 0);
    check("done counter", dut.word_count, (accepted > 8) ? 8 : accepted);
    step();
    #3;
    check("idle stall", stall, 0);
    check("idle cache_miss", cache_miss, 0);
  endtask

  initial begin
    logic [15:0] addr;
    logic [11:0] blk;

    clear_inputs();
    rst = 1'b1;
    access_valid = 1'b1; access_address = 16'hBEEF;
    cache_updating = 1'b1; cache_write_tag_array = 1'b1; cache_write_data_array = 1'b1;
    #3;
    check("reset stall", stall, 0);
    check("reset cache_miss", cache_miss, 0);
    check("reset miss address", cache_miss_address, 0);
    check("reset fill_block", fill_block, 0);
    check("reset tag_we", tag_we, 0);
    check("reset data_we", data_we, 0);
    check("reset fill_done", fill_done, 0);
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b0;

    // Hit: no stall, no state change; stray tag write in IDLE is ignored.
    step(); clear_inputs();
    access_valid = 1'b1; tag_hit = 1'b1; access_address = 16'h1234;
    cache_updating = 1'b1; cache_write_tag_array = 1'b1;
    #3;
    check("hit stall", stall, 0);
    check("idle stray tag_we", tag_we, 0);
    step(); clear_inputs();
    #3;
    check("hit no miss", cache_miss, 0);
    check("hit stall after", stall, 0);

    run_fill(16'h1234, 8, 1'b0, 1'b0, 1'b0);
    run_fill(16'h4ABC, 8, 1'b1, 1'b0, 1'b0);
    run_fill(16'h1234, 8, 1'b0, 1'b0, 1'b1);

    // Reset during word 5 abandons the fill without a tag write.
    addr = 16'h2468;
    blk  = addr[15:4];
    step(); clear_inputs();
    access_valid = 1'b1; access_address = addr;
    step(); clear_inputs();
    cache_updating = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); clear_inputs();
      cache_updating = 1'b1; cache_write_data_array = 1'b1;
      ram_data_address = {blk, 3'(i), 1'b0};
      ram_data_out = 16'(16'hC0 + i);
      exp_q.push_back('{0, 3'(i), ram_data_out, blk});
    end
    step(); clear_inputs();
    cache_updating = 1'b1; cache_write_data_array = 1'b1;
    ram_data_address = {blk, 3'd5, 1'b0}; ram_data_out = 16'h00C5;
    #2;
    rst = 1'b1;
    #1;
    check("rst cache_miss", cache_miss, 0);
    check("rst stall", stall, 0);
    check("rst data_we", data_we, 0);
    check("rst miss address", cache_miss_address, 0);
    cache_write_tag_array = 1'b1;
    #1;
    check("rst tag_we", tag_we, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      cache_updating = 1'b1; cache_write_tag_array = 1'b1; cache_write_data_array = 1'b1;
      #3;
      check("post-rst tag_we", tag_we, 0);
      check("post-rst data_we", data_we, 0);
      check("post-rst cache_miss", cache_miss, 0);
    end
    step(); clear_inputs();

    for (int t = 0; t < 25; t++) begin
      run_fill(16'($urandom), $urandom_range(1, 10), ($urandom % 4 == 0), 1'b1, 1'b0);
    end

    repeat (3) step();
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 8: words per cache block; the word offset is log2(BLOCK_WORDS) bits wide.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port access_valid, input, 1: the pipeline is presenting a cache access this cycle.
REQ-005 SHALL have port access_address, input, 16: byte address of that access.
REQ-006 SHALL have port tag_hit, input, 1: result of the cache tag compare for access_address.
REQ-007 SHALL have port cache_miss, output, 1: fill request to the memory controller.
REQ-008 SHALL have port cache_miss_address, output, 16: captured miss address.
REQ-009 SHALL have port cache_updating, input, 1: the memory controller is currently filling this cache.
REQ-010 SHALL have port cache_write_data_array, input, 1: returned word valid this cycle.
REQ-011 SHALL have port cache_write_tag_array, input, 1: the controller signals block complete.
REQ-012 SHALL have port ram_data_address, input, 16: address of the returned word.
REQ-013 SHALL have port ram_data_out, input, 16: returned word.
REQ-014 SHALL have port data_we, output, 1: data array write enable.
REQ-015 SHALL have port data_word_offset, output, 3: word index within the block.
REQ-016 SHALL have port data_wdata, output, 16: word to write.
REQ-017 SHALL have port tag_we, output, 1: tag/valid array write enable.
REQ-018 SHALL have port fill_block, output, 12: block address (miss address bits 15:4) for both arrays.
REQ-019 SHALL have port stall, output, 1: holds the pipeline.
REQ-020 SHALL have port fill_done, output, 1: one-cycle pulse when a fill completes.

Function
REQ-021 SHALL implement 4 states: IDLE, REQ (waiting for cache_updating), FILL, DONE.
REQ-022 IDLE: access_valid & ~tag_hit SHALL capture access_address and enter REQ; stall SHALL be asserted combinationally in that same cycle.
REQ-023 cache_miss SHALL be high exactly in REQ and FILL (registered state decode); it rises the cycle after the miss is detected.
REQ-024 cache_miss_address SHALL be the captured address and SHALL stay stable from REQ until the return to IDLE.
REQ-025 REQ→FILL SHALL occur when cache_updating=1; the word counter is cleared on entry.
REQ-026 FILL: data_we SHALL equal cache_write_data_array & (ram_data_address[15:4] == captured[15:4]).
REQ-027 FILL: data_word_offset = ram_data_address[3:1] and data_wdata = ram_data_out, combinationally (zero latency).
REQ-028 A 4-bit word counter SHALL increment on each accepted data_we and saturate at BLOCK_WORDS.
REQ-029 FILL: tag_we SHALL equal cache_write_tag_array; on the same edge the FSM SHALL go to DONE.
REQ-030 Preemption: in FILL, if cache_updating falls without a tag write, the FSM SHALL return to REQ and clear the counter, with cache_miss still high; the refill restarts from word 0.
REQ-031 DONE SHALL last exactly 1 cycle with fill_done=1 and stall=1, then go to IDLE, where the access re-checks tag_hit.
REQ-032 stall SHALL be 1 in REQ, FILL and DONE.
REQ-033 cache_write_data_array or cache_write_tag_array arriving outside FILL SHALL be ignored: no data_we, no tag_we.
REQ-034 fill_block SHALL always equal captured[15:4].
REQ-035 A counter value other than BLOCK_WORDS at the tag write SHALL NOT block completion; the counter is observability only.

Reset
REQ-036 rst SHALL force IDLE, counter=0 and captured address=0 immediately, independent of clk.
REQ-037 While rst=1, all outputs SHALL be 0 except those derived from the zeroed registers.
REQ-038 rst asserted mid-fill SHALL abandon the fill without issuing tag_we.

Structure
REQ-039 State encodings (2-bit) and BLOCK_WORDS SHALL live in the shared cache package, also used by the memory controller.
REQ-040 The state register, counter and address capture SHALL use the existing dff cell; the counter SHALL use incrementer_4_bit as its one sub-module.

Verification
REQ-041 Miss at address 0x1234 → cache_miss=1 next cycle with cache_miss_address=0x1234; stall=1 from the detect cycle.
REQ-042 Then cache_updating=1 and 8 words 0xA0..0xA7 at 0x1230..0x123E, tag write on the last word → offsets 0..7 written, tag_we=1 once, fill_done=1 one cycle later, stall=0 the cycle after.
REQ-043 cache_updating drops after 3 words → state=REQ, cache_miss=1, counter=0; a full refill then completes normally.
REQ-044 A word with ram_data_address=0x5670 during a fill of 0x1234 → data_we=0.
REQ-045 rst pulsed during word 5 → immediate IDLE, cache_miss=0, and no tag_we ever issued.
REQ-046 access_valid=1, tag_hit=1 → stall=0, no state change; a stray cache_write_tag_array while in IDLE → tag_we=0.
